// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Purpose:
//   UART transmit stage. Bytes written by the register block are queued in a
//   small FIFO and sent on TxD as asynchronous frames (start, 8 data bits LSB
//   first, optional even parity, stop), each bit held CLK_DIV clock cycles.
//   Back-to-back frames are sent with no idle gap when the FIFO has data.
//
// Build option:
//   UART_TX_PARITY_EN - when defined, an even-parity bit is inserted between
//                       the last data bit and the stop bit (11-bit frame).
//                       When undefined the frame is 8N1.
//
// Parameters:
//   CLK_DIV    - pClk cycles per serial bit (2..65535)
//   FIFO_DEPTH - FIFO byte slots (power of two, 2..16)
//
// Ports:
//   pClk       in   system clock, rising edge
//   pReset     in   asynchronous active-high reset
//   wr_en      in   write strobe, one byte per asserted cycle
//   wr_data    in   byte to queue
//   TxD        out  serial line, idle high, driven straight from a flop
//   full       out  FIFO holds FIFO_DEPTH entries
//   busy       out  frame in progress or FIFO non-empty
//   fifo_count out  FIFO occupancy
//   overflow   out  one-cycle pulse when a write is dropped because full
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        pClk,
    input  logic                        pReset,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    output logic                        TxD,
    output logic                        full,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLK_DIV);

    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]    r_mem [0:FIFO_DEPTH-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Serializer state
    logic [2:0]    r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_data;

    // Registered outputs
    logic          r_txd;
    logic          r_full;
    logic          r_busy;
    logic          r_overflow;

    logic          w_accept;
    logic          w_pop;
    logic          w_baud_done;
    logic [2:0]    w_state_next;
    logic [2:0]    w_bit_next;
    logic [BW-1:0] w_baud_next;
    logic [7:0]    w_data_next;
    logic [CW-1:0] w_count_next;
    logic          w_txd_next;

    // r_full always equals (r_count == FIFO_DEPTH), so a pop in the same
    // cycle never frees a slot for a write that arrives while full.
    assign w_accept    = wr_en & ~r_full;
    assign w_baud_done = (r_baud == BAUD_LAST);

    always_comb begin
        w_state_next = r_state;
        w_bit_next   = r_bit;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_state_next = S_DATA;
                    w_bit_next   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_done) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_done) begin
                    // Chain straight into the next start bit when data waits.
                    if (r_count != '0) begin
                        w_pop        = 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_data_next = w_pop ? r_mem[r_rd_ptr] : r_data;

        case ({w_accept, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase

        // Baud counter restarts on any state change and at each bit boundary.
        if ((w_state_next != r_state) || w_baud_done || (r_state == S_IDLE)) begin
            w_baud_next = '0;
        end else begin
            w_baud_next = r_baud + BW'(1);
        end

        // TxD is computed from the next state so the line changes on the same
        // edge the state does (start bit begins on the pop edge).
        case (w_state_next)
            S_START:  w_txd_next = 1'b0;
            S_DATA:   w_txd_next = w_data_next[w_bit_next];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_txd_next = ^w_data_next;
`endif
            default:  w_txd_next = 1'b1;
        endcase
    end

    // FIFO payload; contents need no reset because pointers are cleared.
    always_ff @(posedge pClk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge pClk or posedge pReset) begin
        if (pReset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_state    <= S_IDLE;
            r_baud     <= '0;
            r_bit      <= 3'd0;
            r_data     <= 8'd0;
            r_txd      <= 1'b1;
            r_full     <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count    <= w_count_next;
            r_state    <= w_state_next;
            r_baud     <= w_baud_next;
            r_bit      <= w_bit_next;
            r_data     <= w_data_next;
            r_txd      <= w_txd_next;
            r_full     <= (w_count_next == COUNT_FULL);
            r_busy     <= (w_state_next != S_IDLE) | (w_count_next != '0);
            r_overflow <= wr_en & r_full;
        end
    end

    assign TxD        = r_txd;
    assign full       = r_full;
    assign busy       = r_busy;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Scoreboard bench. The driver keeps an abstract model (a byte queue plus the
// number of cycles left in the frame on the line) and pushes each byte it
// expects on the wire, with its expected start cycle, into exp_q. A separate
// receiver process watches TxD, pops exp_q at each start bit and checks every
// line cycle and the decoded byte. Status outputs are checked every cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;
    localparam int CD    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int NSEG  = 11;
`else
    localparam int NSEG  = 10;
`endif
    localparam int FRAME = NSEG * CD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'd0;
    logic          txd;
    logic          full;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    uart_tx_serializer #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
        .pClk       (clk),
        .pReset     (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .TxD        (txd),
        .full       (full),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        int         t;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_pend[$];
    int         m_rem = 0;
    bit         m_ovf = 1'b0;
    bit         mon_busy = 1'b0;
    int         rx_frames = 0;
    int         ovf_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic expected_bit(input logic [7:0] b, input int seg);
        if (seg == 0) return 1'b0;
        if (seg <= 8) return b[seg-1];
`ifdef UART_TX_PARITY_EN
        if (seg == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic check_status();
        check("fifo_count", 32'(fifo_count), 32'(m_pend.size()));
        check("full", 32'(full), 32'(m_pend.size() == DEPTH));
        check("busy", 32'(busy), 32'((m_rem != 0) || (m_pend.size() != 0)));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (m_rem == 0) check("txd_idle", 32'(txd), 32'd1);
    endtask

    // One upcoming clock edge of the abstract model: frames last FRAME cycles,
    // a new frame starts when the line is free and a byte is already queued,
    // and a write is kept only if the queue was not full before the edge.
    function automatic void model_step(input bit w, input logic [7:0] d);
        bit   f;
        exp_t e;
        f     = (m_pend.size() == DEPTH);
        m_ovf = w && f;
        if (m_rem <= 1) begin
            if (m_pend.size() != 0) begin
                e.b = m_pend.pop_front();
                e.t = cyc + 1;
                exp_q.push_back(e);
                m_rem = FRAME;
            end else begin
                m_rem = 0;
            end
        end else begin
            m_rem--;
        end
        if (w && !f) m_pend.push_back(d);
    endfunction

    task automatic step(input bit w, input logic [7:0] d, input bit gate_full, output bit did);
        @(negedge clk);
        check_status();
        did     = w && !(gate_full && (full === 1'b1));
        wr_en   = did;
        wr_data = d;
        model_step(did, d);
        @(posedge clk);
    endtask

    task automatic drain();
        bit d;
        for (int i = 0; i < 3000; i++) begin
            if (m_rem == 0 && m_pend.size() == 0 && !mon_busy && exp_q.size() == 0) begin
                repeat (3) step(1'b0, 8'd0, 1'b0, d);
                return;
            end
            step(1'b0, 8'd0, 1'b0, d);
        end
        total++;
        bad++;
        $display("FAIL drain_timeout: got busy expected idle within 3000 cycles");
    endtask

    task automatic model_reset();
        m_pend.delete();
        exp_q.delete();
        m_rem = 0;
        m_ovf = 1'b0;
    endtask

    // Receiver: samples TxD once per cycle on the falling edge.
    initial begin : receiver
        bit         active = 1'b0;
        bit         has_exp = 1'b0;
        int         idx = 0;
        int         errs = 0;
        int         seg;
        logic [7:0] eb = 8'd0;
        logic [7:0] rb = 8'd0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else begin
                if (!active && txd === 1'b0) begin
                    active = 1'b1;
                    idx    = 0;
                    errs   = 0;
                    rb     = 8'd0;
                    if (exp_q.size() == 0) begin
                        has_exp = 1'b0;
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame: got start bit expected idle line (cycle %0d)", cyc);
                    end else begin
                        e       = exp_q.pop_front();
                        has_exp = 1'b1;
                        eb      = e.b;
                        check("start_time", 32'(cyc), 32'(e.t));
                    end
                end
                if (active) begin
                    seg = idx / CD;
                    if (txd !== expected_bit(eb, seg)) errs++;
                    if (seg >= 1 && seg <= 8 && (idx % CD) == CD / 2) rb[seg-1] = txd;
                    idx++;
                    if (idx == FRAME) begin
                        active = 1'b0;
                        rx_frames++;
                        if (has_exp) begin
                            check("frame_bits", 32'(errs), 32'd0);
                            check("rx_byte", 32'(rb), 32'(eb));
                        end
                    end
                end
            end
            mon_busy = active;
        end
    end

    initial begin : ovf_counter
        forever begin
            @(negedge clk);
            if (overflow === 1'b1) ovf_pulses++;
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit d;
        int f0;
        int p0;
        int n;

        // Reset values while reset is held
        rst = 1'b1;
        repeat (3) step(1'b0, 8'd0, 1'b0, d);
        #2 rst = 1'b0;
        repeat (2) step(1'b0, 8'd0, 1'b0, d);

        // Single byte
        step(1'b1, 8'hA5, 1'b0, d);
        drain();

        // Back-to-back frames
        step(1'b1, 8'h00, 1'b0, d);
        step(1'b1, 8'hFF, 1'b0, d);
        drain();

        // Overflow: six consecutive writes
        f0 = rx_frames;
        p0 = ovf_pulses;
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0, d);
        drain();
        check("ovf_pulses", 32'(ovf_pulses - p0), 32'd1);
        check("ovf_frames", 32'(rx_frames - f0), 32'd5);

        // Wrap-around stream, writing only while not full
        f0 = rx_frames;
        n  = 0;
        for (int i = 0; i < 2000 && n < 10; i++) begin
            step(1'b1, 8'(n + 1), 1'b1, d);
            if (d) n++;
        end
        check("wrap_written", 32'(n), 32'd10);
        drain();
        check("wrap_frames", 32'(rx_frames - f0), 32'd10);

        // Parity-relevant bytes (odd and even popcount)
        step(1'b1, 8'h07, 1'b0, d);
        step(1'b1, 8'h03, 1'b0, d);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, 8'($urandom), 1'b0, d);
        end
        drain();

        // Reset in the middle of a frame
        step(1'b1, 8'h3C, 1'b0, d);
        step(1'b1, 8'h11, 1'b0, d);
        step(1'b1, 8'h22, 1'b0, d);
        repeat (5) step(1'b0, 8'd0, 1'b0, d);
        #3;
        check("txd_before_rst", 32'(txd), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        model_reset();
        repeat (2) step(1'b0, 8'd0, 1'b0, d);
        #2 rst = 1'b0;
        step(1'b1, 8'h5A, 1'b0, d);
        drain();

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit stage downstream of the UART register block. It accepts bytes written to the transmit data register and buffers them in a small FIFO. It serialises each byte onto the `TxD` line as an 8N1 asynchronous frame at a fixed clocks-per-bit rate, and reports `full`/`busy`/`overflow` status back to the register block for `pReadData` status reads.

## Interface
- `CLK_DIV`, default 16: `pClk` cycles per serial bit; legal range 2–65535.
- `FIFO_DEPTH`, default 4: byte slots; power of two, 2–16.
- `pClk`  in  1  system clock; all logic on its rising edge.
- `pReset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe from register block; one byte per asserted cycle.
- `wr_data`  in  8  byte to transmit; sampled when `wr_en` is high.
- `TxD`  out  1  serial output; idle high.
- `full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `busy`  out  1  a frame is on the line, or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  one-cycle pulse when a write is dropped.

## Operation
- **FIFO acceptance**
  - A write is accepted iff `wr_en` is high and `full` is low, evaluated against pre-edge state.
  - With `wr_en` high and `full` high, the byte is discarded and `overflow` pulses for 1 cycle.
  - A pop in the same cycle does not make room for a write while full.
- **Pointers**
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
  - A simultaneous accepted write and pop leaves `fifo_count` unchanged.
- **FSM states:** IDLE, START, DATA, [PARITY], STOP.
  - IDLE: `TxD`=1. If `fifo_count`≠0, pop the head into the shift register and go to START.
  - START: `TxD`=0 for `CLK_DIV` cycles, then go to DATA.
  - DATA: send 8 bits LSB first, each held `CLK_DIV` cycles; a 3-bit counter selects the bit. After bit 7, go to PARITY if built in, else STOP.
  - STOP: `TxD`=1 for `CLK_DIV` cycles.
  - End of STOP with FIFO non-empty: pop and go directly to START, so back-to-back frames have no idle gap.
  - End of STOP with FIFO empty: go to IDLE.
- **Baud counter:** counts 0..`CLK_DIV`-1 and restarts at 0 on every state change.
- `busy` = (state≠IDLE) | (`fifo_count`≠0).
- A write landing in the same cycle as IDLE's pop check is not visible until the next cycle.

## Timing
- **Reset values** (asynchronous, take effect immediately):
  - `TxD`=1, `full`=0, `busy`=0, `fifo_count`=0, `overflow`=0.
  - State=IDLE; pointers and counters cleared.
- **Reset mid-frame:** the frame is truncated, `TxD` returns high at once, and FIFO contents are discarded.
- **Write-to-line latency** (from a write accepted at edge E0 into an empty, idle block):
  - `fifo_count`=1 after E0.
  - At E1 the byte is popped and `TxD` falls.
  - The start bit therefore begins 1 cycle after the write edge.
- **Frame length:** 10×`CLK_DIV` cycles, or 11×`CLK_DIV` with parity.
- **Output registering:** all outputs are registered; `TxD` comes straight from a flop with no glitches.
- **Status timing:** `full` and `overflow` update on the edge after the causing event.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- **Defined:** the PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for `CLK_DIV` cycles.
  - Frame length becomes 11×`CLK_DIV`.
- **Undefined:** the PARITY state and its logic are absent, and the frame is 8N1.

## Test plan
- **Reset:** `CLK_DIV`=4, assert `pReset` mid-frame.
  - `TxD` goes to 1 immediately; `fifo_count`=0, `busy`=0.
- **Single byte:** `CLK_DIV`=4, write 0xA5.
  - `TxD` = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, starting 1 cycle after the write.
  - `busy` falls 40 cycles after `TxD` first goes low.
- **Back-to-back frames:** write 0x00 then 0xFF on consecutive cycles.
  - The 0xFF start bit follows the first stop bit with no idle cycle.
  - Total `busy` time is 80 cycles.
- **Overflow:** `FIFO_DEPTH`=4, `CLK_DIV`=16, write 6 bytes on consecutive cycles.
  - The first byte pops immediately, so 5 are accepted, `full` sets, and the 6th write pulses `overflow`.
  - The 6th byte never appears on `TxD`.
- **Wrap-around:** stream 10 bytes 0x01..0x0A, writing only while `full`=0.
  - All 10 bytes are received in order by a bench UART receiver model.
- **Parity:** with `UART_TX_PARITY_EN` defined, `CLK_DIV`=4.
  - Byte 0x07 gives parity bit 1; byte 0x03 gives parity bit 0.
  - Each frame is 44 cycles.
